// File: rtl/glob_config_sequencer_if.sv
// Configuration, phase and issue signals between the global sequencer and its environment.
// GLOB_SEQ_PERF_EN adds the scenario/issue performance counters to the bundle.
interface glob_config_sequencer_if #(
    parameter int N_LC                 = 4,
    parameter int sample_address_width = 8,
    parameter int address_vector_width = 4
);
    localparam int SEL_W = (N_LC > 1) ? $clog2(N_LC) : 1;

    logic                            cfg_we;
    logic                            cfg_type;
    logic [SEL_W-1:0]                cfg_sel;
    logic [sample_address_width-1:0] cfg_delay;
    logic [address_vector_width-1:0] cfg_dest;
    logic [sample_address_width-1:0] cfg_pf_start;
    logic [sample_address_width-1:0] cfg_pf_stop;
    logic [address_vector_width-1:0] cfg_pf_dest;
    logic                            cfg_ready;
    logic                            go;
    logic                            abort;
    logic [15:0]                     scenario_len;
    logic                            boot_up;
    logic                            start;
    logic                            write_flag_0;
    logic                            scenario_update;
    logic [N_LC-1:0]                 from_glob_controller_valid;
    logic [sample_address_width-1:0] from_glob_controller_delay;
    logic [address_vector_width-1:0] from_glob_dest_addr;
    logic [N_LC-1:0]                 from_glob_prefetch_valid;
    logic [sample_address_width-1:0] from_glob_prefetch_start;
    logic [sample_address_width-1:0] from_glob_prefetch_stop;
    logic [address_vector_width-1:0] from_glob_prefetch_dest;
    logic                            busy;
`ifdef GLOB_SEQ_PERF_EN
    logic [15:0]                     scenario_count;
    logic [15:0]                     issue_count;

    modport master (
        output cfg_we, cfg_type, cfg_sel, cfg_delay, cfg_dest, cfg_pf_start, cfg_pf_stop,
               cfg_pf_dest, go, abort, scenario_len,
        input  cfg_ready, boot_up, start, write_flag_0, scenario_update,
               from_glob_controller_valid, from_glob_controller_delay, from_glob_dest_addr,
               from_glob_prefetch_valid, from_glob_prefetch_start, from_glob_prefetch_stop,
               from_glob_prefetch_dest, busy, scenario_count, issue_count
    );

    modport slave (
        input  cfg_we, cfg_type, cfg_sel, cfg_delay, cfg_dest, cfg_pf_start, cfg_pf_stop,
               cfg_pf_dest, go, abort, scenario_len,
        output cfg_ready, boot_up, start, write_flag_0, scenario_update,
               from_glob_controller_valid, from_glob_controller_delay, from_glob_dest_addr,
               from_glob_prefetch_valid, from_glob_prefetch_start, from_glob_prefetch_stop,
               from_glob_prefetch_dest, busy, scenario_count, issue_count
    );
`else
    modport master (
        output cfg_we, cfg_type, cfg_sel, cfg_delay, cfg_dest, cfg_pf_start, cfg_pf_stop,
               cfg_pf_dest, go, abort, scenario_len,
        input  cfg_ready, boot_up, start, write_flag_0, scenario_update,
               from_glob_controller_valid, from_glob_controller_delay, from_glob_dest_addr,
               from_glob_prefetch_valid, from_glob_prefetch_start, from_glob_prefetch_stop,
               from_glob_prefetch_dest, busy
    );

    modport slave (
        input  cfg_we, cfg_type, cfg_sel, cfg_delay, cfg_dest, cfg_pf_start, cfg_pf_stop,
               cfg_pf_dest, go, abort, scenario_len,
        output cfg_ready, boot_up, start, write_flag_0, scenario_update,
               from_glob_controller_valid, from_glob_controller_delay, from_glob_dest_addr,
               from_glob_prefetch_valid, from_glob_prefetch_start, from_glob_prefetch_stop,
               from_glob_prefetch_dest, busy
    );
`endif
endinterface

// File: rtl/glob_config_sequencer.sv
// Global configuration sequencer: stages per-controller entries and drives boot/start/scenario phases.
// Optional macro GLOB_SEQ_PERF_EN adds scenario_count and issue_count.
module glob_config_sequencer #(
    parameter int N_LC                 = 4,
    parameter int sample_address_width = 8,
    parameter int address_vector_width = 4,
    parameter int BOOT_CYCLES          = 6,
    parameter int START_GAP            = 13
) (
    input logic                    CLK,
    input logic                    reset,
    glob_config_sequencer_if.slave bus
);
    localparam int SEL_W = (N_LC > 1) ? $clog2(N_LC) : 1;
    localparam logic [15:0] BOOT_LAST = 16'(BOOT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(START_GAP - 1);
    localparam logic [N_LC-1:0] ONE_LC = {{(N_LC-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_BOOT, S_GAP, S_START, S_RUN} state_t;

    state_t                          r_state;
    logic [15:0]                     r_cnt;
    logic [15:0]                     r_scen_cnt;
    logic                            r_boot_up;
    logic                            r_start;
    logic                            r_wf0;
    logic                            r_scen_upd;
    logic                            r_ctl_open;

    logic [N_LC-1:0]                 r_pend_ctl;
    logic [N_LC-1:0]                 r_pend_pf;
    logic [sample_address_width-1:0] r_slot_delay    [N_LC];
    logic [address_vector_width-1:0] r_slot_dest     [N_LC];
    logic [sample_address_width-1:0] r_slot_pf_start [N_LC];
    logic [sample_address_width-1:0] r_slot_pf_stop  [N_LC];
    logic [address_vector_width-1:0] r_slot_pf_dest  [N_LC];

    logic [N_LC-1:0]                 r_ctl_valid;
    logic [sample_address_width-1:0] r_ctl_delay;
    logic [address_vector_width-1:0] r_ctl_dest;
    logic [N_LC-1:0]                 r_pf_valid;
    logic [sample_address_width-1:0] r_pf_start;
    logic [sample_address_width-1:0] r_pf_stop;
    logic [address_vector_width-1:0] r_pf_dest;

    logic                            w_cfg_ready;
    logic                            w_wr;
    logic [N_LC-1:0]                 w_set_ctl;
    logic [N_LC-1:0]                 w_set_pf;
    logic                            w_ctl_elig;
    logic                            w_pf_elig;
    logic [N_LC-1:0]                 w_elig_ctl;
    logic [N_LC-1:0]                 w_elig_pf;
    logic [SEL_W-1:0]                w_ctl_idx;
    logic [SEL_W-1:0]                w_pf_idx;
    logic                            w_do_ctl;
    logic                            w_do_pf;
    logic [N_LC-1:0]                 w_clr_ctl;
    logic [N_LC-1:0]                 w_clr_pf;
    logic [N_LC-1:0]                 w_pend_ctl_nxt;
    logic [N_LC-1:0]                 w_pend_pf_nxt;
    logic                            w_pend_empty_nxt;

    assign w_cfg_ready = bus.cfg_type ? ~r_pend_pf[bus.cfg_sel] : ~r_pend_ctl[bus.cfg_sel];
    assign w_wr        = bus.cfg_we & w_cfg_ready;
    assign w_set_ctl   = (w_wr & ~bus.cfg_type) ? (ONE_LC << bus.cfg_sel) : {N_LC{1'b0}};
    assign w_set_pf    = (w_wr &  bus.cfg_type) ? (ONE_LC << bus.cfg_sel) : {N_LC{1'b0}};

    // Abort suppresses any issue so the entry stays pending for the next boot.
    assign w_ctl_elig = ~bus.abort & ((r_state == S_BOOT) | ((r_state == S_RUN) & r_ctl_open));
    assign w_pf_elig  = ~bus.abort & ((r_state == S_BOOT) | (r_state == S_RUN));
    assign w_elig_ctl = r_pend_ctl & {N_LC{w_ctl_elig}};
    assign w_elig_pf  = r_pend_pf  & {N_LC{w_pf_elig}};

    // Fixed-priority arbiter: controller entries before prefetch entries, lowest index first.
    always_comb begin
        w_ctl_idx = {SEL_W{1'b0}};
        w_pf_idx  = {SEL_W{1'b0}};
        w_do_ctl  = 1'b0;
        w_do_pf   = 1'b0;
        w_clr_ctl = {N_LC{1'b0}};
        w_clr_pf  = {N_LC{1'b0}};
        for (int i = N_LC - 1; i >= 0; i--) begin
            w_ctl_idx = w_elig_ctl[i] ? SEL_W'(i) : w_ctl_idx;
            w_pf_idx  = w_elig_pf[i]  ? SEL_W'(i) : w_pf_idx;
        end
        if (|w_elig_ctl) begin
            w_do_ctl  = 1'b1;
            w_clr_ctl = ONE_LC << w_ctl_idx;
        end else if (|w_elig_pf) begin
            w_do_pf  = 1'b1;
            w_clr_pf = ONE_LC << w_pf_idx;
        end else begin
            w_do_pf = 1'b0;
        end
    end

    assign w_pend_ctl_nxt   = (r_pend_ctl | w_set_ctl) & ~w_clr_ctl;
    assign w_pend_pf_nxt    = (r_pend_pf  | w_set_pf)  & ~w_clr_pf;
    assign w_pend_empty_nxt = ~|{w_pend_ctl_nxt, w_pend_pf_nxt};

    // Slot storage, pending bits and the registered issue stage.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pend_ctl  <= {N_LC{1'b0}};
            r_pend_pf   <= {N_LC{1'b0}};
            r_ctl_valid <= {N_LC{1'b0}};
            r_pf_valid  <= {N_LC{1'b0}};
            r_ctl_delay <= {sample_address_width{1'b0}};
            r_ctl_dest  <= {address_vector_width{1'b0}};
            r_pf_start  <= {sample_address_width{1'b0}};
            r_pf_stop   <= {sample_address_width{1'b0}};
            r_pf_dest   <= {address_vector_width{1'b0}};
            for (int i = 0; i < N_LC; i++) begin
                r_slot_delay[i]    <= {sample_address_width{1'b0}};
                r_slot_dest[i]     <= {address_vector_width{1'b0}};
                r_slot_pf_start[i] <= {sample_address_width{1'b0}};
                r_slot_pf_stop[i]  <= {sample_address_width{1'b0}};
                r_slot_pf_dest[i]  <= {address_vector_width{1'b0}};
            end
        end else begin
            r_pend_ctl  <= w_pend_ctl_nxt;
            r_pend_pf   <= w_pend_pf_nxt;
            r_ctl_valid <= w_clr_ctl;
            r_pf_valid  <= w_clr_pf;
            if (w_wr && !bus.cfg_type) begin
                r_slot_delay[bus.cfg_sel] <= bus.cfg_delay;
                r_slot_dest[bus.cfg_sel]  <= bus.cfg_dest;
            end else if (w_wr) begin
                r_slot_pf_start[bus.cfg_sel] <= bus.cfg_pf_start;
                r_slot_pf_stop[bus.cfg_sel]  <= bus.cfg_pf_stop;
                r_slot_pf_dest[bus.cfg_sel]  <= bus.cfg_pf_dest;
            end else begin
                r_slot_delay[bus.cfg_sel] <= r_slot_delay[bus.cfg_sel];
            end
            if (w_do_ctl) begin
                r_ctl_delay <= r_slot_delay[w_ctl_idx];
                r_ctl_dest  <= r_slot_dest[w_ctl_idx];
            end else begin
                r_ctl_delay <= r_ctl_delay;
            end
            if (w_do_pf) begin
                r_pf_start <= r_slot_pf_start[w_pf_idx];
                r_pf_stop  <= r_slot_pf_stop[w_pf_idx];
                r_pf_dest  <= r_slot_pf_dest[w_pf_idx];
            end else begin
                r_pf_start <= r_pf_start;
            end
        end
    end

    // Phase state machine with registered phase outputs.
    always_ff @(posedge CLK) begin
        if (reset || bus.abort) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_scen_cnt <= 16'd0;
            r_boot_up  <= 1'b0;
            r_start    <= 1'b0;
            r_wf0      <= 1'b0;
            r_scen_upd <= 1'b0;
            r_ctl_open <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_wf0      <= 1'b0;
            r_scen_upd <= 1'b0;
            r_ctl_open <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_state   <= S_BOOT;
                        r_boot_up <= 1'b1;
                        r_cnt     <= 16'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BOOT: begin
                    // Boot stretches until the staged queue has fully drained.
                    if ((r_cnt >= BOOT_LAST) && w_pend_empty_nxt) begin
                        r_state   <= S_GAP;
                        r_boot_up <= 1'b0;
                        r_cnt     <= 16'd0;
                    end else begin
                        r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_START;
                        r_start <= 1'b1;
                        r_wf0   <= 1'b1;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_START: begin
                    r_state    <= S_RUN;
                    r_scen_cnt <= 16'd0;
                end
                S_RUN: begin
                    if (bus.scenario_len == 16'd0) begin
                        r_scen_cnt <= 16'd0;
                    end else if (r_scen_cnt >= bus.scenario_len - 16'd1) begin
                        r_scen_cnt <= 16'd0;
                        r_scen_upd <= 1'b1;
                    end else begin
                        r_scen_cnt <= r_scen_cnt + 16'd1;
                    end
                    // Controller entries open one cycle after a scenario boundary.
                    if (r_scen_upd) begin
                        r_ctl_open <= 1'b1;
                    end else if (~|w_pend_ctl_nxt) begin
                        r_ctl_open <= 1'b0;
                    end else begin
                        r_ctl_open <= r_ctl_open;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready                  = w_cfg_ready;
    assign bus.boot_up                    = r_boot_up;
    assign bus.start                      = r_start;
    assign bus.write_flag_0               = r_wf0;
    assign bus.scenario_update            = r_scen_upd;
    assign bus.from_glob_controller_valid = r_ctl_valid;
    assign bus.from_glob_controller_delay = r_ctl_delay;
    assign bus.from_glob_dest_addr        = r_ctl_dest;
    assign bus.from_glob_prefetch_valid   = r_pf_valid;
    assign bus.from_glob_prefetch_start   = r_pf_start;
    assign bus.from_glob_prefetch_stop    = r_pf_stop;
    assign bus.from_glob_prefetch_dest    = r_pf_dest;
    assign bus.busy                       = (r_state != S_IDLE);

`ifdef GLOB_SEQ_PERF_EN
    logic [15:0] r_scen_count;
    logic [15:0] r_issue_count;

    // Event counters wrap at 16 bits and clear only on reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_scen_count  <= 16'd0;
            r_issue_count <= 16'd0;
        end else begin
            r_scen_count  <= r_scen_upd ? r_scen_count + 16'd1 : r_scen_count;
            r_issue_count <= (|{r_ctl_valid, r_pf_valid}) ? r_issue_count + 16'd1 : r_issue_count;
        end
    end

    assign bus.scenario_count = r_scen_count;
    assign bus.issue_count    = r_issue_count;
`else
    // Performance counters are not built.
`endif
endmodule

// File: tb/tb_glob_config_sequencer.sv
// Directed bench for glob_config_sequencer with hand-computed expectations.
module tb_glob_config_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cnt;
    int   hits;

    glob_config_sequencer_if bus ();

    glob_config_sequencer dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic t, input int sel, input logic [7:0] a,
                             input logic [7:0] b, input logic [3:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_type = t;
        bus.cfg_sel  = 2'(sel);
        if (t) begin
            bus.cfg_pf_start = a;
            bus.cfg_pf_stop  = b;
            bus.cfg_pf_dest  = d;
        end else begin
            bus.cfg_delay = a;
            bus.cfg_dest  = d;
        end
        tick;
        bus.cfg_we = 1'b0;
    endtask

    task automatic check_ready(input string tag, input logic t, input int sel, input logic exp);
        bus.cfg_type = t;
        bus.cfg_sel  = 2'(sel);
        #1;
        check_eq(tag, bus.cfg_ready, exp);
    endtask

    task automatic pulse_go;
        bus.go = 1'b1;
        tick;
        bus.go = 1'b0;
    endtask

    task automatic wait_boot_fall(input string tag);
        cnt = 0;
        while (bus.boot_up === 1'b1 && cnt < 100) begin
            tick;
            cnt++;
        end
        check_eq(tag, bus.boot_up, 1'b0);
    endtask

    // Counts cycles from the first boot_up-low cycle to the start pulse.
    task automatic check_gap(input string tag);
        cnt = 0;
        while (bus.start !== 1'b1 && cnt < 60) begin
            tick;
            cnt++;
        end
        check_eq({tag, "_gap"}, cnt, 13);
        check_eq({tag, "_wf0"}, bus.write_flag_0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_boot"}, bus.boot_up, 1'b0);
        check_eq({tag, "_start"}, bus.start, 1'b0);
        check_eq({tag, "_wf0"}, bus.write_flag_0, 1'b0);
        check_eq({tag, "_su"}, bus.scenario_update, 1'b0);
        check_eq({tag, "_cv"}, bus.from_glob_controller_valid, 4'h0);
        check_eq({tag, "_cd"}, bus.from_glob_controller_delay, 8'h00);
        check_eq({tag, "_cdst"}, bus.from_glob_dest_addr, 4'h0);
        check_eq({tag, "_pv"}, bus.from_glob_prefetch_valid, 4'h0);
        check_eq({tag, "_ps"}, bus.from_glob_prefetch_start, 8'h00);
        check_eq({tag, "_pe"}, bus.from_glob_prefetch_stop, 8'h00);
        check_eq({tag, "_pd"}, bus.from_glob_prefetch_dest, 4'h0);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        for (int s = 0; s < 4; s++) begin
            check_ready({tag, "_rdy_c"}, 1'b0, s, 1'b1);
            check_ready({tag, "_rdy_p"}, 1'b1, s, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.cfg_we = 1'b0; bus.cfg_type = 1'b0; bus.cfg_sel = 2'd0;
        bus.cfg_delay = 8'h00; bus.cfg_dest = 4'h0;
        bus.cfg_pf_start = 8'h00; bus.cfg_pf_stop = 8'h00; bus.cfg_pf_dest = 4'h0;
        bus.go = 1'b0; bus.abort = 1'b0; bus.scenario_len = 16'd0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        check_all_zero("rst0");

        // Single prefetch entry: boot lasts the minimum six cycles.
        cfg_write(1'b1, 2, 8'h19, 8'h20, 4'b1000);
        check_ready("t2_rdy_busy", 1'b1, 2, 1'b0);
        cfg_write(1'b1, 2, 8'h55, 8'h66, 4'b0001);
        pulse_go;
        check_eq("t2_b1_boot", bus.boot_up, 1'b1);
        check_eq("t2_b1_pv", bus.from_glob_prefetch_valid, 4'h0);
        tick;
        check_eq("t2_b2_pv", bus.from_glob_prefetch_valid, 4'b0100);
        check_eq("t2_b2_ps", bus.from_glob_prefetch_start, 8'h19);
        check_eq("t2_b2_pe", bus.from_glob_prefetch_stop, 8'h20);
        check_eq("t2_b2_pd", bus.from_glob_prefetch_dest, 4'b1000);
        check_eq("t2_b2_cv", bus.from_glob_controller_valid, 4'h0);
        hits = 2;
        cnt = 0;
        while (bus.boot_up === 1'b1 && cnt < 100) begin
            tick;
            cnt++;
            if (bus.boot_up === 1'b1) hits++;
        end
        check_eq("t2_boot_len", hits, 6);
        check_gap("t2");
        tick;
        check_eq("t2_start_1cyc", bus.start, 1'b0);
        check_eq("t2_run_busy", bus.busy, 1'b1);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        check_eq("t2_abort_busy", bus.busy, 1'b0);

        // All eight slots: boot stretches to eight cycles.
        for (int i = 0; i < 4; i++) cfg_write(1'b0, i, 8'(16 + i), 8'h00, 4'(i + 1));
        for (int i = 0; i < 4; i++) cfg_write(1'b1, i, 8'(64 + i), 8'(80 + i), 4'(i + 8));
        bus.scenario_len = 16'd16;
        pulse_go;
        for (int k = 0; k < 8; k++) begin
            tick;
            check_eq("t3_boot", bus.boot_up, (k < 7) ? 1 : 0);
            if (k < 4) begin
                check_eq("t3_cv", bus.from_glob_controller_valid, 32'(1 << k));
                check_eq("t3_cd", bus.from_glob_controller_delay, 32'(16 + k));
                check_eq("t3_cdst", bus.from_glob_dest_addr, 32'(k + 1));
                check_eq("t3_pv0", bus.from_glob_prefetch_valid, 4'h0);
            end else begin
                check_eq("t3_pv", bus.from_glob_prefetch_valid, 32'(1 << (k - 4)));
                check_eq("t3_ps", bus.from_glob_prefetch_start, 32'(64 + k - 4));
                check_eq("t3_pe", bus.from_glob_prefetch_stop, 32'(80 + k - 4));
                check_eq("t3_pd", bus.from_glob_prefetch_dest, 32'(k + 4));
                check_eq("t3_cv0", bus.from_glob_controller_valid, 4'h0);
            end
        end
        check_gap("t3");

        // Scenario pulses every 16 RUN cycles, none when scenario_len is 0.
        cnt = 0;
        while (bus.scenario_update !== 1'b1 && cnt < 40) begin
            tick;
            cnt++;
        end
        check_eq("t4_first_su", bus.scenario_update, 1'b1);
        for (int p = 0; p < 2; p++) begin
            cnt = 0;
            do begin
                tick;
                cnt++;
            end while (bus.scenario_update !== 1'b1 && cnt < 40);
            check_eq("t4_period", cnt, 16);
        end
        bus.scenario_len = 16'd0;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (bus.scenario_update === 1'b1) hits++;
        end
        check_eq("t4_len0_pulses", hits, 0);

        // In RUN, prefetch issues at once; controller waits for the next boundary.
        cfg_write(1'b0, 1, 8'h5A, 8'h00, 4'b0011);
        cfg_write(1'b1, 3, 8'h30, 8'hE0, 4'b0110);
        check_eq("t5_pv_sel", bus.from_glob_prefetch_valid, 4'h0);
        tick;
        check_eq("t5_pv", bus.from_glob_prefetch_valid, 4'b1000);
        check_eq("t5_ps", bus.from_glob_prefetch_start, 8'h30);
        check_eq("t5_pe", bus.from_glob_prefetch_stop, 8'hE0);
        check_eq("t5_pd", bus.from_glob_prefetch_dest, 4'b0110);
        check_eq("t5_cv_early", bus.from_glob_controller_valid, 4'h0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.from_glob_controller_valid !== 4'h0) hits++;
        end
        check_eq("t5_cv_held", hits, 0);
        check_ready("t5_rdy_c1", 1'b0, 1, 1'b0);
        bus.scenario_len = 16'd4;
        cnt = 0;
        while (bus.scenario_update !== 1'b1 && cnt < 20) begin
            tick;
            cnt++;
            if (bus.from_glob_controller_valid !== 4'h0) hits++;
        end
        check_eq("t5_su_seen", bus.scenario_update, 1'b1);
        check_eq("t5_cv_before", hits, 0);
        tick;
        check_eq("t5_cv_s1", bus.from_glob_controller_valid, 4'h0);
        tick;
        check_eq("t5_cv_s2", bus.from_glob_controller_valid, 4'b0010);
        check_eq("t5_cd", bus.from_glob_controller_delay, 8'h5A);
        check_eq("t5_cdst", bus.from_glob_dest_addr, 4'b0011);
        tick;
        check_eq("t5_cv_s3", bus.from_glob_controller_valid, 4'h0);
        check_ready("t5_rdy_c1_free", 1'b0, 1, 1'b1);

        // Abort keeps pending entries; they are reissued on the next boot.
        bus.scenario_len = 16'd0;
        cfg_write(1'b0, 2, 8'h77, 8'h00, 4'b0101);
        tick;
        check_eq("t6_cv_held", bus.from_glob_controller_valid, 4'h0);
        bus.abort = 1'b1;
        bus.go    = 1'b1;
        tick;
        bus.abort = 1'b0;
        bus.go    = 1'b0;
        check_eq("t6_abort_busy", bus.busy, 1'b0);
        tick;
        check_eq("t6_go_ignored", bus.busy, 1'b0);
        pulse_go;
        tick;
        check_eq("t6_reissue_cv", bus.from_glob_controller_valid, 4'b0100);
        check_eq("t6_reissue_cd", bus.from_glob_controller_delay, 8'h77);
        check_eq("t6_reissue_cdst", bus.from_glob_dest_addr, 4'b0101);
        wait_boot_fall("t6_boot_fell");
        cfg_write(1'b1, 1, 8'hA1, 8'hB2, 4'b0011);
        for (int i = 0; i < 3; i++) tick;
        check_eq("t6_gap_pv", bus.from_glob_prefetch_valid, 4'h0);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        check_eq("t6_gap_abort_busy", bus.busy, 1'b0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.start === 1'b1) hits++;
            tick;
        end
        check_eq("t6_no_start", hits, 0);
        pulse_go;
        check_eq("t6_reboot", bus.boot_up, 1'b1);
        tick;
        check_eq("t6_pf_reissue", bus.from_glob_prefetch_valid, 4'b0010);
        check_eq("t6_pf_ps", bus.from_glob_prefetch_start, 8'hA1);
        check_eq("t6_pf_pe", bus.from_glob_prefetch_stop, 8'hB2);
        check_eq("t6_pf_pd", bus.from_glob_prefetch_dest, 4'b0011);

        // Reset in RUN with a pending entry clears everything.
        wait_boot_fall("t7_boot_fell");
        check_gap("t7");
        tick;
        check_eq("t7_run_busy", bus.busy, 1'b1);
        cfg_write(1'b0, 3, 8'h33, 8'h00, 4'b1111);
        check_ready("t7_rdy_c3", 1'b0, 3, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_all_zero("rst_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/glob_config_sequencer.md
Name: glob_config_sequencer

Overview:
- Global-side sequencer for a ring of N_LC local_controller_prefetch_full instances.
- Holds per-controller configuration: read delay + destination, and prefetch start/stop/destination.
- Drives the system phase signals boot_up, start, write_flag_0 and scenario_update.
- Issues staged configuration to the controllers as one-cycle valid pulses, one controller per cycle, on shared payload buses.

Parameters:
- N_LC, 4, number of local controllers; valid vectors and selects scale with it.
- sample_address_width, 8, width of delay and prefetch addresses.
- address_vector_width, 4, width of destination vectors.
- BOOT_CYCLES, 6, minimum boot_up assertion length in cycles.
- START_GAP, 13, idle cycles between boot_up deassertion and the start pulse.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_type  in  1  0 = controller entry (delay/dest), 1 = prefetch entry.
- cfg_sel  in  $clog2(N_LC)  target controller index.
- cfg_delay  in  sample_address_width  read delay (type 0).
- cfg_dest  in  address_vector_width  destination (type 0).
- cfg_pf_start  in  sample_address_width  prefetch start address (type 1).
- cfg_pf_stop  in  sample_address_width  prefetch stop address (type 1).
- cfg_pf_dest  in  address_vector_width  prefetch destination (type 1).
- cfg_ready  out  1  combinational; = ~pending[cfg_type][cfg_sel].
- go  in  1  begin the boot sequence; honoured only in IDLE.
- abort  in  1  return to IDLE.
- scenario_len  in  16  RUN cycles per scenario; 0 disables scenario_update.
- boot_up  out  1  boot phase indicator.
- start  out  1  one-cycle start pulse.
- write_flag_0  out  1  one-cycle write-enable pulse to controller 0.
- scenario_update  out  1  one-cycle scenario boundary pulse.
- from_glob_controller_valid  out  N_LC  one-hot issue of a controller entry.
- from_glob_controller_delay  out  sample_address_width  shared delay payload.
- from_glob_dest_addr  out  address_vector_width  shared destination payload.
- from_glob_prefetch_valid  out  N_LC  one-hot issue of a prefetch entry.
- from_glob_prefetch_start  out  sample_address_width  shared prefetch start payload.
- from_glob_prefetch_stop  out  sample_address_width  shared prefetch stop payload.
- from_glob_prefetch_dest  out  address_vector_width  shared prefetch destination payload.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: every output is 0, state is IDLE, all pending bits and payload registers clear.
- Config write: accepted when cfg_we && cfg_ready. It stores the payload in slot [cfg_type][cfg_sel] and sets that slot's pending bit next cycle. A write with cfg_ready low is dropped and nothing changes.
- Issue arbiter: at most one issue per cycle, registered, so valid and payload appear the cycle after selection.
  - Priority: eligible type-0 entries over eligible type-1 entries; within a type, lowest index first.
  - Issuing clears the slot's pending bit.
  - Payload buses hold their last value when no valid is asserted.
- Eligibility:
  - BOOT: all pending entries are eligible.
  - RUN: type-1 entries are eligible at any time. Type-0 entries become eligible only from the cycle after a scenario_update pulse, and stay eligible until no type-0 entry remains pending.
  - IDLE, GAP, START: nothing is eligible.
- State machine (states IDLE, BOOT, GAP, START, RUN):
  - IDLE -> BOOT on go.
  - BOOT: boot_up=1. Advance to GAP once at least BOOT_CYCLES cycles have elapsed AND no pending entries remain (boot extends until the queue drains).
  - GAP: outputs low for START_GAP cycles, then advance to START.
  - START: single cycle with start=1 and write_flag_0=1; then advance to RUN.
  - RUN: a 16-bit counter counts from 0. When it reaches scenario_len-1, scenario_update pulses and the counter returns to 0. With scenario_len=0 the counter is held at 0 and no pulse is produced. RUN persists until abort.
- abort (any state): next cycle goes to IDLE with all phase outputs and valids low. Pending bits and payloads are retained. go in the same cycle as abort is ignored.
- go outside IDLE is ignored.
- Write to a slot while it is being issued: cannot happen, because cfg_ready is low while the slot is pending.

Optional Feature:
- Macro: GLOB_SEQ_PERF_EN.
- Defined: adds outputs scenario_count[15:0] and issue_count[15:0].
  - scenario_count counts scenario_update pulses; issue_count counts all issued valids.
  - Both wrap at 0xFFFF and clear only on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN (reset=1 for 1 cycle) -> next cycle every output is 0, busy=0, and all cfg_ready=1.
- Write prefetch slot 2 (start 0x19, dest 4'b1000), then go -> boot_up high 6 cycles. Prefetch valid 4'b0100 appears in the 2nd BOOT cycle with start=0x19. start and write_flag_0 pulse exactly 13 cycles after boot_up falls.
- Write all 8 slots, then go -> 8 consecutive valid pulses in order: controller 0..3, then prefetch 0..3. boot_up is held 8 cycles, not 6.
- scenario_len=16 in RUN -> scenario_update pulses every 16 cycles. scenario_len=0 -> no pulse over 100 cycles.
- In RUN write prefetch slot 3 (0x30/0xE0/0110) and controller slot 1 -> prefetch valid issues immediately. The controller valid issues only the cycle after the next scenario_update.
- abort during GAP -> IDLE next cycle with start never asserted. Re-go re-runs BOOT, and entries still pending are reissued.
